// File: rtl/tdm_demux4_if.sv
// Link-side bundle for the 4-channel TDM demux: serial beat input and published frame output.
interface tdm_demux4_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_sync;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic             out_valid;
  logic [1:0]       sel;
  logic             frame_err;
  logic             locked;

  modport master (
    output in_valid, in_sync, din,
    input  out0, out1, out2, out3, out_valid, sel, frame_err, locked
  );

  modport slave (
    input  in_valid, in_sync, din,
    output out0, out1, out2, out3, out_valid, sel, frame_err, locked
  );
endinterface

// File: rtl/tdm_demux4.sv
// Collects four serial channel beats into shadow registers and publishes them as one frame.
// Frame outputs update one cycle after the ch3 beat; sync misplacement pulses frame_err.
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic [WIDTH-1:0] out3_q, out3_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      out3_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      out3_q      <= out3_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    out3_d      = out3_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;

    if (bus.in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_sync) begin
            sh0_d   = bus.din;
            sel_d   = 2'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.in_sync) begin
            // A sync anywhere but slot 0 abandons the partial frame and restarts at ch0.
            frame_err_d = (sel_q != 2'd0);
            sh0_d       = bus.din;
            sel_d       = 2'd1;
          end else begin
            unique case (sel_q)
              2'd0: begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
                sel_d       = 2'd0;
              end
              2'd1: begin
                sh1_d = bus.din;
                sel_d = 2'd2;
              end
              2'd2: begin
                sh2_d = bus.din;
                sel_d = 2'd3;
              end
              2'd3: begin
                out0_d      = sh0_q;
                out1_d      = sh1_q;
                out2_d      = sh2_q;
                out3_d      = bus.din;
                out_valid_d = 1'b1;
                sel_d       = 2'd0;
              end
              default: sel_d = 2'd0;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.out0      = out0_q;
  assign bus.out1      = out1_q;
  assign bus.out2      = out2_q;
  assign bus.out3      = out3_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.sel       = sel_q;
  assign bus.locked    = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: scenario tasks with inline checks plus a frame scoreboard on out_valid.
module tb_tdm_demux4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_q[$];

  tdm_demux4_if #(.WIDTH(4)) bus ();

  tdm_demux4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Scoreboard: each published frame must match the oldest expected frame.
  always @(negedge clk) begin
    logic [15:0] e;
    logic [15:0] got;
    got = {bus.out3, bus.out2, bus.out1, bus.out0};
    if (bus.out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_frame got=%h none expected", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL sb_frame got=%h expected=%h", got, e);
        end
      end
    end
    if (bus.out_valid || bus.frame_err) begin
      checks++;
      if (bus.out_valid && bus.frame_err) begin
        errors++;
        $display("FAIL sb_exclusive out_valid=%b frame_err=%b expected not both", bus.out_valid, bus.frame_err);
      end
    end
  end

  // Drive one beat at a negedge; returns at the next negedge with its result visible.
  task automatic send(input bit s, input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_sync  = s;
    bus.din      = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.din      = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({bus.out3, bus.out2, bus.out1, bus.out0, bus.out_valid, bus.frame_err, bus.sel, bus.locked} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state got=%h/%b/%b/%0d/%b expected all zero",
               {bus.out3, bus.out2, bus.out1, bus.out0}, bus.out_valid, bus.frame_err, bus.sel, bus.locked);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_filter;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 4'(i + 3));
      checks++;
      if ({bus.out_valid, bus.frame_err, bus.sel, bus.locked} !== 5'b0) begin
        errors++;
        $display("FAIL idle_filter beat%0d ov=%b fe=%b sel=%0d lk=%b expected 0/0/0/0",
                 i, bus.out_valid, bus.frame_err, bus.sel, bus.locked);
      end
    end
  endtask

  task automatic test_basic;
    send(1'b1, 4'h1);
    checks++;
    if (bus.sel !== 2'd1 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL basic_lock sel=%0d lk=%b expected 1/1", bus.sel, bus.locked);
    end
    send(1'b0, 4'h2);
    send(1'b0, 4'h4);
    exp_q.push_back(16'h8421);
    send(1'b0, 4'h8);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sel !== 2'd0 || bus.locked !== 1'b1 ||
        {bus.out3, bus.out2, bus.out1, bus.out0} !== 16'h8421) begin
      errors++;
      $display("FAIL basic_frame ov=%b sel=%0d lk=%b outs=%h expected 1/0/1/8421",
               bus.out_valid, bus.sel, bus.locked, {bus.out3, bus.out2, bus.out1, bus.out0});
    end
    idle(1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_width ov=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    send(1'b1, 4'hA);
    send(1'b0, 4'hB);
    for (int i = 0; i < 2; i++) begin
      idle(1);
      checks++;
      if (bus.sel !== 2'd2 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL gap_hold cyc%0d sel=%0d ov=%b expected 2/0", i, bus.sel, bus.out_valid);
      end
    end
    send(1'b0, 4'hC);
    exp_q.push_back(16'hDCBA);
    send(1'b0, 4'hD);
    send(1'b1, 4'h5);
    send(1'b0, 4'h6);
    send(1'b0, 4'h7);
    exp_q.push_back(16'h9765);
    send(1'b0, 4'h9);
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.out3, bus.out2, bus.out1, bus.out0} !== 16'h9765) begin
      errors++;
      $display("FAIL b2b_second ov=%b outs=%h expected 1/9765",
               bus.out_valid, {bus.out3, bus.out2, bus.out1, bus.out0});
    end
  endtask

  task automatic test_early_sync;
    send(1'b1, 4'h3);
    send(1'b0, 4'h4);
    send(1'b1, 4'h5);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.sel !== 2'd1 || bus.locked !== 1'b1 ||
        {bus.out3, bus.out2, bus.out1, bus.out0} !== 16'h9765) begin
      errors++;
      $display("FAIL early_sync fe=%b sel=%0d lk=%b outs=%h expected 1/1/1/9765",
               bus.frame_err, bus.sel, bus.locked, {bus.out3, bus.out2, bus.out1, bus.out0});
    end
    send(1'b0, 4'h6);
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL early_sync_pulse fe=%b expected 0", bus.frame_err);
    end
    send(1'b0, 4'h7);
    exp_q.push_back(16'h8765);
    send(1'b0, 4'h8);
  endtask

  task automatic test_missing_sync;
    send(1'b1, 4'h1);
    send(1'b0, 4'h2);
    send(1'b0, 4'h3);
    exp_q.push_back(16'h4321);
    send(1'b0, 4'h4);
    send(1'b0, 4'hF);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.locked !== 1'b0 || bus.sel !== 2'd0 ||
        {bus.out3, bus.out2, bus.out1, bus.out0} !== 16'h4321) begin
      errors++;
      $display("FAIL missing_sync fe=%b lk=%b sel=%0d outs=%h expected 1/0/0/4321",
               bus.frame_err, bus.locked, bus.sel, {bus.out3, bus.out2, bus.out1, bus.out0});
    end
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 4'(i + 1));
      checks++;
      if (bus.frame_err !== 1'b0 || bus.locked !== 1'b0 || bus.sel !== 2'd0) begin
        errors++;
        $display("FAIL unlocked_ignore beat%0d fe=%b lk=%b sel=%0d expected 0/0/0",
                 i, bus.frame_err, bus.locked, bus.sel);
      end
    end
    send(1'b1, 4'h7);
    checks++;
    if (bus.locked !== 1'b1 || bus.sel !== 2'd1) begin
      errors++;
      $display("FAIL relock lk=%b sel=%0d expected 1/1", bus.locked, bus.sel);
    end
    send(1'b0, 4'h8);
    send(1'b0, 4'h9);
    exp_q.push_back(16'hA987);
    send(1'b0, 4'hA);
  endtask

  task automatic test_async_reset;
    send(1'b1, 4'h1);
    send(1'b0, 4'h2);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({bus.out3, bus.out2, bus.out1, bus.out0, bus.out_valid, bus.frame_err, bus.sel, bus.locked} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset outs=%h ov=%b fe=%b sel=%0d lk=%b expected all zero",
               {bus.out3, bus.out2, bus.out1, bus.out0}, bus.out_valid, bus.frame_err, bus.sel, bus.locked);
    end
    @(negedge clk);
    rst = 1'b0;
    send(1'b1, 4'hE);
    send(1'b0, 4'hD);
    send(1'b0, 4'hC);
    exp_q.push_back(16'hBCDE);
    send(1'b0, 4'hB);
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.out3, bus.out2, bus.out1, bus.out0} !== 16'hBCDE) begin
      errors++;
      $display("FAIL post_reset_frame ov=%b outs=%h expected 1/bcde",
               bus.out_valid, {bus.out3, bus.out2, bus.out1, bus.out0});
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.din      = 4'h0;
    test_reset();
    test_idle_filter();
    test_basic();
    test_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_async_reset();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
